// File: rtl/buffered_accumulator.sv
`timescale 1ns/1ps
// buffered_accumulator
// Captures a host-selected number of stream words into an internal buffer,
// then reads the buffer back and reduces it to one result (unsigned sum or
// bitwise XOR). The job sequences itself through IDLE -> WRITE -> READ -> DONE.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     one-cycle job request (honoured only in IDLE)
//   len       words in job, legal 1..DEPTH, sampled with start
//   mode      0 = unsigned sum, 1 = XOR, sampled with start
//   in_valid  producer has a word
//   in_data   stream word
//   in_ready  word is accepted this cycle when in_valid is also high
//   busy      job in progress (state != IDLE)
//   done      one-cycle pulse, sum_out valid
//   err       one-cycle pulse, start rejected for an illegal len
//   sum_out   result; XOR result zero-extended; held until next job/reset
//   state     IDLE=0, WRITE=1, READ=2, DONE=3
module buffered_accumulator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned SUM_W  = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SUM_W-1:0]  sum_out,
    output logic [1:0]        state
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_len;
    logic              r_mode;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_rcnt;
    logic [SUM_W-1:0]  r_acc;
    logic [SUM_W-1:0]  r_sum_out;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [1:0]        w_next_state;
    logic              w_len_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_accept;
    logic              w_last_write;
    logic              w_last_read;
    logic              w_fold_valid;
    logic [SUM_W-1:0]  w_fold;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_in_ready_d;
    logic              w_busy_d;
    logic              w_done_d;
    logic              w_err_d;

    // Job qualification and datapath decode
    assign w_len_ok     = (len != '0) && (len <= CNT_W'(DEPTH));
    assign w_start_ok   = (r_state == S_IDLE) && start && w_len_ok;
    assign w_start_bad  = (r_state == S_IDLE) && start && !w_len_ok;
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_write = w_accept && (r_wcnt == (r_len - CNT_W'(1)));
    // READ cycle k issues address k; cycles 1..len see data for address k-1
    assign w_last_read  = (r_state == S_READ) && (r_rcnt == r_len);
    assign w_fold_valid = (r_state == S_READ) && (r_rcnt != '0);
    assign w_raddr      = r_rcnt[ADDR_W-1:0];
    assign w_fold       = r_mode ? (r_acc ^ SUM_W'(r_rdata))
                                 : (r_acc + SUM_W'(r_rdata));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)   w_next_state = S_WRITE;
            S_WRITE: if (w_last_write) w_next_state = S_READ;
            S_READ:  if (w_last_read)  w_next_state = S_DONE;
            S_DONE:                    w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so flags line up with state
    always_comb begin
        w_in_ready_d = 1'b0;
        w_busy_d     = 1'b0;
        w_done_d     = 1'b0;
        w_err_d      = 1'b0;
        w_in_ready_d = (w_next_state == S_WRITE);
        w_busy_d     = (w_next_state != S_IDLE);
        w_done_d     = (w_next_state == S_DONE);
        w_err_d      = w_start_bad;
    end

    // Output flags, job registers, counters and accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sum_out  <= '0;
            r_len      <= '0;
            r_mode     <= 1'b0;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_acc      <= '0;
        end else begin
            r_in_ready <= w_in_ready_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
            if (w_start_ok) begin
                r_len  <= len;
                r_mode <= mode;
                r_wcnt <= '0;
                r_rcnt <= '0;
                r_acc  <= '0;
            end
            if (w_accept) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end
            if (r_state == S_READ) begin
                r_rcnt <= r_rcnt + CNT_W'(1);
                if (w_fold_valid) begin
                    r_acc <= w_fold;
                end
                // Publish the final fold directly so sum_out is valid with done
                if (w_last_read) begin
                    r_sum_out <= w_fold;
                end
            end
        end
    end

    // Buffer memory: contents survive reset; read has one-cycle latency
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wcnt[ADDR_W-1:0]] <= in_data;
        end
        r_rdata <= r_mem[w_raddr];
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign sum_out  = r_sum_out;
    assign state    = r_state;

endmodule

// File: tb/tb_buffered_accumulator.sv
`timescale 1ns/1ps
module tb_buffered_accumulator;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned SUM_W  = DATA_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [SUM_W-1:0]  sum_out;
    logic [1:0]        state;

    always #5 clk = ~clk;

    buffered_accumulator #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err), .sum_out(sum_out), .state(state)
    );

    typedef struct {
        logic [SUM_W-1:0] sum;
        int unsigned      cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] words[$];
    int unsigned       cyc = 0;
    int                n_tests = 0;
    int                n_fail = 0;
    logic [SUM_W-1:0]  last_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the reduction of the captured words, by plain arithmetic
    function automatic logic [SUM_W-1:0] model_result(input logic m);
        longint unsigned acc = 0;
        foreach (words[i]) acc = m ? (acc ^ 64'(words[i])) : (acc + 64'(words[i]));
        return SUM_W'(acc);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding job
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_without_job: actual=done expected=no done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("sum_out", 64'(sum_out), 64'(e.sum));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
        check({tag, "_sum_out"},  64'(sum_out),  64'd0);
        check({tag, "_state"},    64'(state),    64'd0);
    endtask

    task automatic start_job(input int unsigned l, input logic m);
        start    = 1'b1;
        len      = (ADDR_W+1)'(l);
        mode     = m;
        in_valid = 1'b1;          // offered in IDLE: must not be captured
        in_data  = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        len      = (ADDR_W+1)'($urandom);
        check("state_write", 64'(state), 64'd1);
        check("busy_set", 64'(busy), 64'd1);
    endtask

    task automatic send_words(input int gap, input bit extra_start, input bit chk,
                              output int unsigned last_acc);
        int          idx = 0;
        int          guard = 0;
        int          ready_cnt = 0;
        int          limit = 4 * words.size() + 50;
        bit          v = 1'b0;
        last_acc = 0;
        while (idx < words.size() && guard < limit) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = ~v;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? words[idx] : DATA_W'($urandom);
            start    = extra_start && (guard == 2);
            if (start) begin
                len  = (ADDR_W+1)'(1);
                mode = ~mode;
            end
            if (chk) check("state_in_write", 64'(state), 64'd1);
            if (in_ready === 1'b1) ready_cnt++;
            if (v && in_ready === 1'b1) begin
                last_acc = cyc;
                idx++;
            end
            guard++;
            @(negedge clk);
            start = 1'b0;
            if (extra_start && guard == 3) check("no_err_while_busy", 64'(err), 64'd0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("words_accepted", 64'(idx), 64'(words.size()));
        if (gap == 0) check("in_ready_cycles", 64'(ready_cnt), 64'(words.size()));
        check("in_ready_drop", 64'(in_ready), 64'd0);
    endtask

    task automatic finish_job(input int unsigned t, input int unsigned l, input logic m,
                              input bit chk);
        exp_t e;
        e.sum = model_result(m);
        e.cyc = t + l + 2;
        sb.push_back(e);
        last_sum = e.sum;
        for (int i = 0; i <= int'(l); i++) begin
            if (chk || i == 0) check("state_read", 64'(state), 64'd2);
            @(negedge clk);
        end
        check("state_done", 64'(state), 64'd3);
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("state_idle", 64'(state), 64'd0);
        check("busy_clear", 64'(busy), 64'd0);
        check("done_single", 64'(done), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_job(input int unsigned l, input logic m, input int gap,
                           input bit extra_start, input bit chk);
        int unsigned t;
        start_job(l, m);
        send_words(gap, extra_start, chk, t);
        finish_job(t, l, m, chk);
    endtask

    task automatic illegal_start(input int unsigned l);
        start    = 1'b1;
        len      = (ADDR_W+1)'(l);
        mode     = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("err_pulse", 64'(err), 64'd1);
        check("err_state_idle", 64'(state), 64'd0);
        check("err_in_ready", 64'(in_ready), 64'd0);
        check("err_busy", 64'(busy), 64'd0);
        check("err_sum_hold", 64'(sum_out), 64'(last_sum));
        @(negedge clk);
        check("err_single", 64'(err), 64'd0);
        check("err_still_idle", 64'(state), 64'd0);
    endtask

    task automatic fill_random(input int unsigned n);
        words.delete();
        for (int i = 0; i < int'(n); i++) words.push_back(DATA_W'($urandom));
    endtask

    initial begin
        int unsigned t;
        int unsigned l;
        reset = 1'b1; start = 1'b0; len = '0; mode = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Basic four-word sum
        words.delete();
        words.push_back(8'h01); words.push_back(8'h02);
        words.push_back(8'h03); words.push_back(8'h04);
        run_job(4, 1'b0, 0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("sum_hold_idle", 64'(sum_out), 64'd10);

        // Full-scale buffer
        words.delete();
        for (int i = 0; i < int'(DEPTH); i++) words.push_back(8'hFF);
        run_job(DEPTH, 1'b0, 0, 1'b0, 1'b0);
        check("full_scale", 64'(sum_out), 64'd130560);

        // XOR job, then single-word sum with no carry-over
        words.delete();
        words.push_back(8'hA5); words.push_back(8'h0F); words.push_back(8'hFF);
        run_job(3, 1'b1, 0, 1'b0, 1'b1);
        check("xor_result", 64'(sum_out), 64'h55);
        words.delete();
        words.push_back(8'h80);
        run_job(1, 1'b0, 0, 1'b0, 1'b1);
        check("single_word", 64'(sum_out), 64'h80);

        // Illegal lengths
        illegal_start(0);
        illegal_start(DEPTH + 1);
        illegal_start(1023);

        // Gapped stream with a stray start during WRITE
        fill_random(5);
        run_job(5, 1'b0, 1, 1'b1, 1'b1);

        // Reset in the middle of READ aborts the job silently
        fill_random(8);
        start_job(8, 1'($urandom_range(0, 1)));
        send_words(0, 1'b0, 1'b1, t);
        repeat (3) @(negedge clk);
        check("abort_in_read", 64'(state), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b0;
        last_sum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 64'(done), 64'd0);
        end
        words.delete();
        words.push_back(8'h10); words.push_back(8'h20);
        run_job(2, 1'b0, 0, 1'b0, 1'b1);
        check("after_abort_sum", 64'(sum_out), 64'h30);

        // Randomised jobs
        for (int j = 0; j < 6; j++) begin
            l = $urandom_range(1, 40);
            fill_random(l);
            run_job(l, 1'($urandom_range(0, 1)), 2, 1'b0, 1'b1);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
